// File: rtl/eda_push_stack_pkg.sv
// Shared types and helpers for the push-stack traversal engine and its
// neighbour address generator: FSM state encoding, window bit positions
// and {i, j} pixel address packing.
package eda_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESENT,
      ST_PUSH,
      ST_POP,
      ST_DONE
   } eda_stack_state_t;

   localparam int NB_COUNT     = 8;
   localparam int NB_UPLEFT    = 7;
   localparam int NB_UP        = 6;
   localparam int NB_UPRIGHT   = 5;
   localparam int NB_LEFT      = 4;
   localparam int NB_RIGHT     = 3;
   localparam int NB_DOWNLEFT  = 2;
   localparam int NB_DOWN      = 1;
   localparam int NB_DOWNRIGHT = 0;

   function automatic int unsigned addr_pack(int unsigned i, int unsigned j, int unsigned j_w);
      return (i << j_w) | j;
   endfunction

   function automatic int unsigned addr_row(int unsigned addr, int unsigned i_w, int unsigned j_w);
      return (addr >> j_w) & ((32'd1 << i_w) - 32'd1);
   endfunction

   function automatic int unsigned addr_col(int unsigned addr, int unsigned j_w);
      return addr & ((32'd1 << j_w) - 32'd1);
   endfunction

endpackage

// File: rtl/eda_push_stack_if.sv
// Handshake bundle between the push-stack engine (slave) and the
// comparator side that seeds regions and returns push masks (master).
// EDA_PUSH_STACK_STATS_EN adds the max_depth / pop_count statistics.
interface eda_push_stack_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int NB_WIDTH   = 8
`ifdef EDA_PUSH_STACK_STATS_EN
   , parameter int PTR_WIDTH = 9
`endif
);
   logic                  clear;
   logic                  seed_valid;
   logic [ADDR_WIDTH-1:0] seed_addr;
   logic                  seed_ready;
   logic                  center_valid;
   logic                  new_pixel;
   logic [ADDR_WIDTH-1:0] center_addr;
   logic [ADDR_WIDTH-1:0] upleft_addr;
   logic [ADDR_WIDTH-1:0] up_addr;
   logic [ADDR_WIDTH-1:0] upright_addr;
   logic [ADDR_WIDTH-1:0] left_addr;
   logic [ADDR_WIDTH-1:0] right_addr;
   logic [ADDR_WIDTH-1:0] downleft_addr;
   logic [ADDR_WIDTH-1:0] down_addr;
   logic [ADDR_WIDTH-1:0] downright_addr;
   logic [NB_WIDTH-1:0]   neighbor_valid;
   logic                  push_valid;
   logic [NB_WIDTH-1:0]   push_positions;
   logic                  region_done;
   logic                  busy;
   logic                  overflow;
`ifdef EDA_PUSH_STACK_STATS_EN
   logic [PTR_WIDTH-1:0]  max_depth;
   logic [ADDR_WIDTH:0]   pop_count;
`endif

   modport master (
      output clear, seed_valid, seed_addr, push_valid, push_positions,
      input  seed_ready, center_valid, new_pixel, center_addr,
             upleft_addr, up_addr, upright_addr, left_addr, right_addr,
             downleft_addr, down_addr, downright_addr, neighbor_valid,
             region_done, busy, overflow
`ifdef EDA_PUSH_STACK_STATS_EN
             , max_depth, pop_count
`endif
   );

   modport slave (
      input  clear, seed_valid, seed_addr, push_valid, push_positions,
      output seed_ready, center_valid, new_pixel, center_addr,
             upleft_addr, up_addr, upright_addr, left_addr, right_addr,
             downleft_addr, down_addr, downright_addr, neighbor_valid,
             region_done, busy, overflow
`ifdef EDA_PUSH_STACK_STATS_EN
             , max_depth, pop_count
`endif
   );
endinterface

// File: rtl/eda_push_stack_neighbor_addr_gen.sv
// Combinational 3x3 window generator: from a centre address produces the
// eight neighbour addresses and their in-bounds mask. Neighbours that
// fall off the image report the centre address with a cleared valid bit.
module eda_neighbor_addr_gen
   import eda_pkg::*;
#(
   parameter int M          = 16,
   parameter int N          = 16,
   parameter int ADDR_WIDTH = $clog2(M*N),
   parameter int I_WIDTH    = $clog2(M),
   parameter int J_WIDTH    = $clog2(N)
) (
   input  logic [ADDR_WIDTH-1:0] i_center_addr,
   output logic [ADDR_WIDTH-1:0] o_upleft_addr,
   output logic [ADDR_WIDTH-1:0] o_up_addr,
   output logic [ADDR_WIDTH-1:0] o_upright_addr,
   output logic [ADDR_WIDTH-1:0] o_left_addr,
   output logic [ADDR_WIDTH-1:0] o_right_addr,
   output logic [ADDR_WIDTH-1:0] o_downleft_addr,
   output logic [ADDR_WIDTH-1:0] o_down_addr,
   output logic [ADDR_WIDTH-1:0] o_downright_addr,
   output logic [NB_COUNT-1:0]   o_neighbor_valid
);
   int unsigned w_i;
   int unsigned w_j;
   logic        w_up_ok;
   logic        w_down_ok;
   logic        w_left_ok;
   logic        w_right_ok;

   // Split the centre into row/column and flag which image borders it touches.
   always_comb begin
      w_i        = addr_row(32'(i_center_addr), I_WIDTH, J_WIDTH);
      w_j        = addr_col(32'(i_center_addr), J_WIDTH);
      w_up_ok    = (w_i != 0);
      w_down_ok  = (w_i != M - 1);
      w_left_ok  = (w_j != 0);
      w_right_ok = (w_j != N - 1);
   end

   // Build the window; out-of-range entries fall back to the centre address.
   always_comb begin
      o_neighbor_valid               = '0;
      o_neighbor_valid[NB_UPLEFT]    = w_up_ok && w_left_ok;
      o_neighbor_valid[NB_UP]        = w_up_ok;
      o_neighbor_valid[NB_UPRIGHT]   = w_up_ok && w_right_ok;
      o_neighbor_valid[NB_LEFT]      = w_left_ok;
      o_neighbor_valid[NB_RIGHT]     = w_right_ok;
      o_neighbor_valid[NB_DOWNLEFT]  = w_down_ok && w_left_ok;
      o_neighbor_valid[NB_DOWN]      = w_down_ok;
      o_neighbor_valid[NB_DOWNRIGHT] = w_down_ok && w_right_ok;

      o_upleft_addr    = o_neighbor_valid[NB_UPLEFT]    ? ADDR_WIDTH'(addr_pack(w_i - 1, w_j - 1, J_WIDTH)) : i_center_addr;
      o_up_addr        = o_neighbor_valid[NB_UP]        ? ADDR_WIDTH'(addr_pack(w_i - 1, w_j,     J_WIDTH)) : i_center_addr;
      o_upright_addr   = o_neighbor_valid[NB_UPRIGHT]   ? ADDR_WIDTH'(addr_pack(w_i - 1, w_j + 1, J_WIDTH)) : i_center_addr;
      o_left_addr      = o_neighbor_valid[NB_LEFT]      ? ADDR_WIDTH'(addr_pack(w_i,     w_j - 1, J_WIDTH)) : i_center_addr;
      o_right_addr     = o_neighbor_valid[NB_RIGHT]     ? ADDR_WIDTH'(addr_pack(w_i,     w_j + 1, J_WIDTH)) : i_center_addr;
      o_downleft_addr  = o_neighbor_valid[NB_DOWNLEFT]  ? ADDR_WIDTH'(addr_pack(w_i + 1, w_j - 1, J_WIDTH)) : i_center_addr;
      o_down_addr      = o_neighbor_valid[NB_DOWN]      ? ADDR_WIDTH'(addr_pack(w_i + 1, w_j,     J_WIDTH)) : i_center_addr;
      o_downright_addr = o_neighbor_valid[NB_DOWNRIGHT] ? ADDR_WIDTH'(addr_pack(w_i + 1, w_j + 1, J_WIDTH)) : i_center_addr;
   end

endmodule

// File: rtl/eda_push_stack.sv
// Regional-maximum traversal engine: holds the LIFO of pending pixels,
// presents each centre with its 3x3 window, serialises the returned push
// mask onto the stack and pops the next centre until the region drains.
// Optional statistics (max_depth, pop_count) under EDA_PUSH_STACK_STATS_EN.
//
// state   | meaning
// IDLE    | waiting for a seed, seed_ready high
// PRESENT | centre and window presented, waiting for push_valid
// PUSH    | one pending neighbour written per cycle, lowest bit first
// POP     | top of stack becomes the next centre
// DONE    | region_done pulse, back to IDLE
module eda_push_stack
   import eda_pkg::*;
#(
   parameter int M            = 16,
   parameter int N            = 16,
   parameter int WINDOW_WIDTH = 9,
   parameter int ADDR_WIDTH   = $clog2(M*N),
   parameter int I_WIDTH      = $clog2(M),
   parameter int J_WIDTH      = $clog2(N),
   parameter int DEPTH        = M*N,
   parameter int PTR_WIDTH    = $clog2(DEPTH+1)
) (
   input  logic           clk,
   input  logic           reset,
   eda_push_stack_if.slave bus
);
   localparam int NB_W  = WINDOW_WIDTH - 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] SP_FULL = PTR_WIDTH'(DEPTH);

   eda_stack_state_t      r_state;
   logic [ADDR_WIDTH-1:0] r_center;
   logic [PTR_WIDTH-1:0]  r_sp;
   logic [NB_W-1:0]       r_pending;
   logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
   logic                  r_overflow;
   logic                  r_seed_ready;
   logic                  r_center_valid;
   logic                  r_new_pixel;
   logic                  r_region_done;
   logic                  r_busy;
`ifdef EDA_PUSH_STACK_STATS_EN
   logic [PTR_WIDTH-1:0]  r_max_depth;
   logic [ADDR_WIDTH:0]   r_pop_count;
`endif

   logic [ADDR_WIDTH-1:0] w_nb_addr [NB_COUNT];
   logic [NB_W-1:0]       w_nb_valid;
   logic [2:0]            w_low_idx;
   logic [ADDR_WIDTH-1:0] w_push_addr;
   logic [ADDR_WIDTH-1:0] w_pop_addr;
   logic [NB_W-1:0]       w_pending_next;
   logic                  w_push_we;
   logic [PTR_WIDTH-1:0]  w_sp_after_push;

   eda_neighbor_addr_gen #(
      .M(M), .N(N), .ADDR_WIDTH(ADDR_WIDTH), .I_WIDTH(I_WIDTH), .J_WIDTH(J_WIDTH)
   ) u_nb (
      .i_center_addr   (r_center),
      .o_upleft_addr   (w_nb_addr[NB_UPLEFT]),
      .o_up_addr       (w_nb_addr[NB_UP]),
      .o_upright_addr  (w_nb_addr[NB_UPRIGHT]),
      .o_left_addr     (w_nb_addr[NB_LEFT]),
      .o_right_addr    (w_nb_addr[NB_RIGHT]),
      .o_downleft_addr (w_nb_addr[NB_DOWNLEFT]),
      .o_down_addr     (w_nb_addr[NB_DOWN]),
      .o_downright_addr(w_nb_addr[NB_DOWNRIGHT]),
      .o_neighbor_valid(w_nb_valid)
   );

   // Pick the lowest pending neighbour and precompute stack pointer effects.
   always_comb begin
      w_low_idx = '0;
      for (int k = NB_W - 1; k >= 0; k--) begin
         if (r_pending[k]) w_low_idx = 3'(k);
      end
      w_push_addr     = w_nb_addr[w_low_idx];
      w_pending_next  = r_pending & (r_pending - NB_W'(1));
      w_push_we       = (r_state == ST_PUSH) && (r_pending != '0) && (r_sp != SP_FULL)
                        && !reset && !bus.clear;
      w_sp_after_push = w_push_we ? r_sp + PTR_WIDTH'(1) : r_sp;
      w_pop_addr      = r_mem[IDX_W'(r_sp - PTR_WIDTH'(1))];
   end

   // Stack storage: a single write per PUSH cycle, contents need no reset.
   always_ff @(posedge clk) begin
      if (w_push_we) r_mem[IDX_W'(r_sp)] <= w_push_addr;
   end

   // Traversal FSM with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_center       <= '0;
         r_sp           <= '0;
         r_pending      <= '0;
         r_overflow     <= 1'b0;
         r_seed_ready   <= 1'b0;
         r_center_valid <= 1'b0;
         r_new_pixel    <= 1'b0;
         r_region_done  <= 1'b0;
         r_busy         <= 1'b0;
`ifdef EDA_PUSH_STACK_STATS_EN
         r_max_depth    <= '0;
         r_pop_count    <= '0;
`endif
      end else if (bus.clear) begin
         r_state        <= ST_IDLE;
         r_sp           <= '0;
         r_pending      <= '0;
         r_overflow     <= 1'b0;
         r_seed_ready   <= 1'b1;
         r_center_valid <= 1'b0;
         r_new_pixel    <= 1'b0;
         r_region_done  <= 1'b0;
         r_busy         <= 1'b0;
`ifdef EDA_PUSH_STACK_STATS_EN
         r_max_depth    <= '0;
         r_pop_count    <= '0;
`endif
      end else begin
         r_new_pixel   <= 1'b0;
         r_region_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_seed_ready <= 1'b1;
               r_busy       <= 1'b0;
               if (bus.seed_valid) begin
                  r_center       <= bus.seed_addr;
                  r_state        <= ST_PRESENT;
                  r_center_valid <= 1'b1;
                  r_new_pixel    <= 1'b1;
                  r_seed_ready   <= 1'b0;
                  r_busy         <= 1'b1;
`ifdef EDA_PUSH_STACK_STATS_EN
                  r_pop_count    <= '0;
`endif
               end
            end
            ST_PRESENT: begin
               if (bus.push_valid) begin
                  r_pending      <= bus.push_positions & w_nb_valid;
                  r_state        <= ST_PUSH;
                  r_center_valid <= 1'b0;
               end
            end
            ST_PUSH: begin
               r_pending <= w_pending_next;
               r_sp      <= w_sp_after_push;
               if ((r_pending != '0) && (r_sp == SP_FULL)) r_overflow <= 1'b1;
`ifdef EDA_PUSH_STACK_STATS_EN
               if (w_sp_after_push > r_max_depth) r_max_depth <= w_sp_after_push;
`endif
               if (w_pending_next == '0) begin
                  if (w_sp_after_push == '0) begin
                     r_state       <= ST_DONE;
                     r_region_done <= 1'b1;
                  end else begin
                     r_state <= ST_POP;
                  end
               end
            end
            ST_POP: begin
               r_center       <= w_pop_addr;
               r_sp           <= r_sp - PTR_WIDTH'(1);
               r_state        <= ST_PRESENT;
               r_center_valid <= 1'b1;
               r_new_pixel    <= 1'b1;
`ifdef EDA_PUSH_STACK_STATS_EN
               r_pop_count    <= r_pop_count + (ADDR_WIDTH+1)'(1);
`endif
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_seed_ready <= 1'b1;
               r_busy       <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.seed_ready     = r_seed_ready;
   assign bus.center_valid   = r_center_valid;
   assign bus.new_pixel      = r_new_pixel;
   assign bus.center_addr    = r_center;
   assign bus.upleft_addr    = w_nb_addr[NB_UPLEFT];
   assign bus.up_addr        = w_nb_addr[NB_UP];
   assign bus.upright_addr   = w_nb_addr[NB_UPRIGHT];
   assign bus.left_addr      = w_nb_addr[NB_LEFT];
   assign bus.right_addr     = w_nb_addr[NB_RIGHT];
   assign bus.downleft_addr  = w_nb_addr[NB_DOWNLEFT];
   assign bus.down_addr      = w_nb_addr[NB_DOWN];
   assign bus.downright_addr = w_nb_addr[NB_DOWNRIGHT];
   assign bus.neighbor_valid = w_nb_valid;
   assign bus.region_done    = r_region_done;
   assign bus.busy           = r_busy;
   assign bus.overflow       = r_overflow;
`ifdef EDA_PUSH_STACK_STATS_EN
   assign bus.max_depth      = r_max_depth;
   assign bus.pop_count      = r_pop_count;
`endif

endmodule

// File: tb/tb_eda_push_stack.sv
// Directed bench for eda_push_stack: default 16x16 instance plus a
// DEPTH=4 instance for the full-stack case.
module tb_eda_push_stack;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

`ifdef EDA_PUSH_STACK_STATS_EN
   eda_push_stack_if #(.ADDR_WIDTH(8), .NB_WIDTH(8), .PTR_WIDTH(9)) bus ();
   eda_push_stack_if #(.ADDR_WIDTH(8), .NB_WIDTH(8), .PTR_WIDTH(3)) bus4 ();
`else
   eda_push_stack_if #(.ADDR_WIDTH(8), .NB_WIDTH(8)) bus ();
   eda_push_stack_if #(.ADDR_WIDTH(8), .NB_WIDTH(8)) bus4 ();
`endif

   eda_push_stack dut (.clk(clk), .reset(reset), .bus(bus));
   eda_push_stack #(.DEPTH(4), .PTR_WIDTH(3)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic seed(input logic [7:0] a);
      bus.seed_addr  = a;
      bus.seed_valid = 1'b1;
      tick();
      bus.seed_valid = 1'b0;
   endtask

   task automatic push(input logic [7:0] p);
      bus.push_positions = p;
      bus.push_valid     = 1'b1;
      tick();
      bus.push_valid     = 1'b0;
   endtask

   // cycles until the next PRESENT or DONE cycle, -1 when none within budget
   task automatic step_until(output int cnt);
      cnt = -1;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (bus.center_valid || bus.region_done) begin
            cnt = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if ({bus.seed_ready, bus.center_valid, bus.new_pixel, bus.region_done, bus.busy, bus.overflow} !== 6'b0) begin
         errors++; $display("FAIL reset_flags got %b exp 000000", {bus.seed_ready, bus.center_valid, bus.new_pixel, bus.region_done, bus.busy, bus.overflow}); end
      checks++; if (bus.center_addr !== 8'h00) begin errors++; $display("FAIL reset_center got %h exp 00", bus.center_addr); end
      checks++; if (bus.neighbor_valid !== 8'b0000_1011) begin errors++; $display("FAIL reset_nvalid got %b exp 00001011", bus.neighbor_valid); end
      reset = 1'b0;
      tick();
      checks++; if (bus.seed_ready !== 1'b1) begin errors++; $display("FAIL reset_seed_ready got %b exp 1", bus.seed_ready); end
      checks++; if (bus4.seed_ready !== 1'b1) begin errors++; $display("FAIL reset_seed_ready4 got %b exp 1", bus4.seed_ready); end
   endtask

   task automatic test_seed_corner();
      seed(8'h00);
      checks++; if ({bus.center_valid, bus.new_pixel, bus.busy, bus.seed_ready} !== 4'b1110) begin
         errors++; $display("FAIL corner_flags got %b exp 1110", {bus.center_valid, bus.new_pixel, bus.busy, bus.seed_ready}); end
      checks++; if (bus.neighbor_valid !== 8'b0000_1011) begin errors++; $display("FAIL corner_nvalid got %b exp 00001011", bus.neighbor_valid); end
      checks++; if ({bus.right_addr, bus.down_addr, bus.downright_addr} !== 24'h01_10_11) begin
         errors++; $display("FAIL corner_addrs got %h exp 011011", {bus.right_addr, bus.down_addr, bus.downright_addr}); end
      checks++; if (bus.up_addr !== 8'h00) begin errors++; $display("FAIL corner_oob_up got %h exp 00", bus.up_addr); end
      tick();
      checks++; if ({bus.center_valid, bus.new_pixel} !== 2'b10) begin errors++; $display("FAIL corner_pulse got %b exp 10", {bus.center_valid, bus.new_pixel}); end
      push(8'h00);
      tick();
      checks++; if (bus.region_done !== 1'b1) begin errors++; $display("FAIL corner_done got %b exp 1", bus.region_done); end
      tick();
   endtask

   task automatic test_full_window();
      logic [7:0] e [8];
      int cnt;
      e = '{8'h44, 8'h45, 8'h46, 8'h54, 8'h56, 8'h64, 8'h65, 8'h66};
      seed(8'h55);
      checks++; if (bus.neighbor_valid !== 8'hFF) begin errors++; $display("FAIL full_nvalid got %h exp ff", bus.neighbor_valid); end
      checks++; if ({bus.upleft_addr, bus.up_addr, bus.upright_addr, bus.left_addr} !== 32'h44_45_46_54) begin
         errors++; $display("FAIL full_upper got %h exp 44454654", {bus.upleft_addr, bus.up_addr, bus.upright_addr, bus.left_addr}); end
      checks++; if ({bus.right_addr, bus.downleft_addr, bus.down_addr, bus.downright_addr} !== 32'h56_64_65_66) begin
         errors++; $display("FAIL full_lower got %h exp 56646566", {bus.right_addr, bus.downleft_addr, bus.down_addr, bus.downright_addr}); end
      push(8'hFF);
      step_until(cnt);
      checks++; if (cnt !== 9) begin errors++; $display("FAIL full_push_len got %0d exp 9", cnt); end
      for (int k = 0; k < 8; k++) begin
         checks++; if (bus.center_addr !== e[k]) begin errors++; $display("FAIL full_pop[%0d] got %h exp %h", k, bus.center_addr, e[k]); end
         checks++; if (bus.new_pixel !== 1'b1) begin errors++; $display("FAIL full_newpix[%0d] got %b exp 1", k, bus.new_pixel); end
         push(8'h00);
         step_until(cnt);
         checks++; if (cnt !== ((k == 7) ? 1 : 2)) begin errors++; $display("FAIL full_step[%0d] got %0d exp %0d", k, cnt, (k == 7) ? 1 : 2); end
      end
      checks++; if (bus.region_done !== 1'b1) begin errors++; $display("FAIL full_done got %b exp 1", bus.region_done); end
      tick();
      checks++; if ({bus.seed_ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL full_idle got %b exp 10", {bus.seed_ready, bus.busy}); end
   endtask

   task automatic test_corner_ff();
      logic [7:0] e [3];
      int cnt;
      e = '{8'hEE, 8'hEF, 8'hFE};
      seed(8'hFF);
      checks++; if (bus.neighbor_valid !== 8'b1101_0000) begin errors++; $display("FAIL ff_nvalid got %b exp 11010000", bus.neighbor_valid); end
      checks++; if ({bus.right_addr, bus.down_addr} !== 16'hFF_FF) begin errors++; $display("FAIL ff_oob got %h exp ffff", {bus.right_addr, bus.down_addr}); end
      push(8'hFF);
      step_until(cnt);
      checks++; if (cnt !== 4) begin errors++; $display("FAIL ff_push_len got %0d exp 4", cnt); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (bus.center_addr !== e[k]) begin errors++; $display("FAIL ff_pop[%0d] got %h exp %h", k, bus.center_addr, e[k]); end
         push(8'h00);
         step_until(cnt);
      end
      checks++; if (bus.region_done !== 1'b1) begin errors++; $display("FAIL ff_done got %b exp 1", bus.region_done); end
      tick();
   endtask

   task automatic test_empty_push();
      seed(8'h33);
      push(8'h00);
      checks++; if ({bus.busy, bus.center_valid, bus.region_done} !== 3'b100) begin
         errors++; $display("FAIL empty_t1 got %b exp 100", {bus.busy, bus.center_valid, bus.region_done}); end
      tick();
      checks++; if ({bus.region_done, bus.seed_ready} !== 2'b10) begin errors++; $display("FAIL empty_t2 got %b exp 10", {bus.region_done, bus.seed_ready}); end
      tick();
      checks++; if ({bus.region_done, bus.seed_ready, bus.busy} !== 3'b010) begin
         errors++; $display("FAIL empty_t3 got %b exp 010", {bus.region_done, bus.seed_ready, bus.busy}); end
   endtask

   task automatic test_ignored();
      bus.push_positions = 8'hFF;
      bus.push_valid     = 1'b1;
      tick();
      tick();
      bus.push_valid     = 1'b0;
      checks++; if ({bus.busy, bus.center_valid} !== 2'b00) begin errors++; $display("FAIL ign_push got %b exp 00", {bus.busy, bus.center_valid}); end
      seed(8'h12);
      bus.seed_addr  = 8'h99;
      bus.seed_valid = 1'b1;
      tick();
      tick();
      bus.seed_valid = 1'b0;
      checks++; if ({bus.center_valid, bus.center_addr} !== {1'b1, 8'h12}) begin
         errors++; $display("FAIL ign_seed got %b/%h exp 1/12", bus.center_valid, bus.center_addr); end
      push(8'h00);
      tick();
      tick();
   endtask

   task automatic test_clear();
      int cnt;
      seed(8'h55);
      push(8'hFF);
      tick();
      tick();
      tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      checks++; if ({bus.busy, bus.seed_ready, bus.region_done, bus.center_valid} !== 4'b0100) begin
         errors++; $display("FAIL clear_idle got %b exp 0100", {bus.busy, bus.seed_ready, bus.region_done, bus.center_valid}); end
      tick();
      checks++; if (bus.region_done !== 1'b0) begin errors++; $display("FAIL clear_nodone got %b exp 0", bus.region_done); end
      seed(8'h00);
      push(8'h00);
      step_until(cnt);
      checks++; if ({bus.region_done, cnt == 1} !== 2'b11) begin errors++; $display("FAIL clear_sp0 got done=%b cnt=%0d exp done=1 cnt=1", bus.region_done, cnt); end
      tick();
   endtask

   task automatic test_overflow();
      logic [7:0] e [4];
      int cnt;
      e = '{8'h56, 8'h64, 8'h65, 8'h66};
      bus4.seed_addr  = 8'h55;
      bus4.seed_valid = 1'b1;
      tick();
      bus4.seed_valid = 1'b0;
      checks++; if (bus4.overflow !== 1'b0) begin errors++; $display("FAIL ovf_initial got %b exp 0", bus4.overflow); end
      bus4.push_positions = 8'h1F;
      for (int k = 0; k <= 4; k++) begin
         if (k < 4) begin
            checks++; if (bus4.center_addr !== ((k == 0) ? 8'h55 : e[k-1])) begin
               errors++; $display("FAIL ovf_center[%0d] got %h exp %h", k, bus4.center_addr, (k == 0) ? 8'h55 : e[k-1]); end
         end
         bus4.push_valid = 1'b1;
         tick();
         bus4.push_valid     = 1'b0;
         bus4.push_positions = 8'h00;
         cnt = -1;
         for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus4.center_valid || bus4.region_done) begin cnt = n; break; end
         end
         if (k == 0) begin
            checks++; if (cnt !== 6) begin errors++; $display("FAIL ovf_push_len got %0d exp 6", cnt); end
         end
         if (k == 4) begin
            checks++; if ({bus4.region_done, cnt == 1} !== 2'b11) begin errors++; $display("FAIL ovf_drain got done=%b cnt=%0d", bus4.region_done, cnt); end
         end
         checks++; if (bus4.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky[%0d] got %b exp 1", k, bus4.overflow); end
         if (k == 3) begin
            checks++; if (bus4.center_addr !== 8'h66) begin errors++; $display("FAIL ovf_last got %h exp 66", bus4.center_addr); end
         end
      end
      tick();
      checks++; if ({bus4.overflow, bus4.seed_ready} !== 2'b11) begin errors++; $display("FAIL ovf_idle got %b exp 11", {bus4.overflow, bus4.seed_ready}); end
      bus4.clear = 1'b1;
      tick();
      bus4.clear = 1'b0;
      checks++; if (bus4.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus4.overflow); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.clear = 1'b0;  bus.seed_valid = 1'b0;  bus.seed_addr = '0;  bus.push_valid = 1'b0;  bus.push_positions = '0;
      bus4.clear = 1'b0; bus4.seed_valid = 1'b0; bus4.seed_addr = '0; bus4.push_valid = 1'b0; bus4.push_positions = '0;
      test_reset();
      test_seed_corner();
      test_full_window();
      test_corner_ff();
      test_empty_push();
      test_ignored();
      test_clear();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
